// File: rtl/motoro3_step_pwm.sv
// motoro3_step_pwm: 3-phase 6-step commutator with PWM-chopped high-side gates.
// Config words are shadowed so a running PWM period never sees mid-period
// changes. The duty is clamped to honour the minimum MOS on/off time, and every
// step change (and every enable rise) opens a dead-time window with all gates off.
// All outputs are registered and are computed from the same next-state values
// as the internal counters, so they stay cycle-aligned with them.
module motoro3_step_pwm #(
  parameter int STEP_W = 25,
  parameter int PCT_W  = 8,
  parameter int PWM_W  = 12,
  parameter int DEAD   = 16
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              en,
  input  logic              dir,
  input  logic [STEP_W-1:0] m3reg_step_cnt_reload1,
  input  logic [PCT_W-1:0]  m3reg_power_percent,
  input  logic [PWM_W-1:0]  pwmLenWant,
  input  logic [PWM_W-1:0]  pwmMinMask,
  output logic [2:0]        m3_step,
  output logic              m3_step_tick,
  output logic              pwm_period_start,
  output logic              pwm_out,
  output logic [2:0]        m3_hi,
  output logic [2:0]        m3_lo
);

  localparam int PROD_W = PWM_W + PCT_W;
  localparam int DEAD_W = $clog2(DEAD + 1);

  localparam logic [DEAD_W-1:0] DEAD_LD   = DEAD_W'(DEAD);
  localparam logic [DEAD_W-1:0] DEAD_ZERO = {DEAD_W{1'b0}};
  localparam logic [DEAD_W-1:0] DEAD_ONE  = DEAD_W'(1);
  localparam logic [PWM_W-1:0]  LEN_ZERO  = {PWM_W{1'b0}};
  localparam logic [PWM_W-1:0]  LEN_ONE   = PWM_W'(1);
  localparam logic [PWM_W-1:0]  LEN_TWO   = PWM_W'(2);
  localparam logic [STEP_W-1:0] STEP_ZERO = {STEP_W{1'b0}};
  localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
  localparam logic [PCT_W-1:0]  PCT_ZERO  = {PCT_W{1'b0}};

  // Count start value for a step: reload-1, with reload 0 behaving like 1.
  function automatic logic [STEP_W-1:0] reload_start(input logic [STEP_W-1:0] r);
    if (r == STEP_ZERO) begin
      reload_start = STEP_ZERO;
    end else begin
      reload_start = r - STEP_ONE;
    end
  endfunction

  // Next commutation step, wrapping 5<->0 in either direction.
  function automatic logic [2:0] step_adv(input logic [2:0] s, input logic d);
    if (d) begin
      step_adv = (s == 3'd0) ? 3'd5 : s - 3'd1;
    end else begin
      step_adv = (s >= 3'd5) ? 3'd0 : s + 3'd1;
    end
  endfunction

  // High-side phase per step, bit order {W,V,U}.
  function automatic logic [2:0] hi_pat(input logic [2:0] s);
    case (s)
      3'd0:    hi_pat = 3'b001;
      3'd1:    hi_pat = 3'b001;
      3'd2:    hi_pat = 3'b010;
      3'd3:    hi_pat = 3'b010;
      3'd4:    hi_pat = 3'b100;
      3'd5:    hi_pat = 3'b100;
      default: hi_pat = 3'b000;
    endcase
  endfunction

  // Low-side phase per step, bit order {W,V,U}.
  function automatic logic [2:0] lo_pat(input logic [2:0] s);
    case (s)
      3'd0:    lo_pat = 3'b010;
      3'd1:    lo_pat = 3'b100;
      3'd2:    lo_pat = 3'b100;
      3'd3:    lo_pat = 3'b001;
      3'd4:    lo_pat = 3'b001;
      3'd5:    lo_pat = 3'b010;
      default: lo_pat = 3'b000;
    endcase
  endfunction

  // State
  logic              en_d;
  logic [STEP_W-1:0] sh_reload;
  logic [PCT_W-1:0]  sh_pct;
  logic [PWM_W-1:0]  sh_len;
  logic [PWM_W-1:0]  sh_min;
  logic [PWM_W-1:0]  duty;
  logic [PWM_W-1:0]  duty_use;
  logic [PWM_W-1:0]  pwm_cnt;
  logic              pwm_run;
  logic [STEP_W-1:0] step_cnt;
  logic [DEAD_W-1:0] dead;

  // Duty path
  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] raw;
  logic [PROD_W-1:0] len_x;
  logic [PROD_W-1:0] min_x;
  logic [PWM_W-1:0]  duty_nx;

  // Next-state path
  logic              en_rise;
  logic              tick_nx;
  logic [2:0]        step_nx;
  logic [STEP_W-1:0] step_cnt_nx;
  logic [DEAD_W-1:0] dead_nx;
  logic              run_nx;
  logic              start_first;
  logic              wrap;
  logic              held_off;
  logic              ps_nx;
  logic              load_sh;
  logic [PWM_W-1:0]  pwm_cnt_nx;
  logic [PWM_W-1:0]  duty_use_nx;
  logic [PWM_W-1:0]  len_gov;
  logic              len_ok_nx;
  logic              pwm_out_nx;
  logic              pulse_nx;
  logic              gate_on;
  logic [2:0]        hi_nx;
  logic [2:0]        lo_nx;

  // Duty from the shadowed config: scale by pct, then clamp to min on/off time.
  always_comb begin
    prod    = PROD_W'(sh_len) * PROD_W'(sh_pct);
    raw     = prod >> PCT_W;
    len_x   = PROD_W'(sh_len);
    min_x   = PROD_W'(sh_min);
    duty_nx = LEN_ZERO;
    if (sh_pct == PCT_ZERO) begin
      duty_nx = LEN_ZERO;
    end else if (raw < min_x) begin
      duty_nx = sh_min;
    end else if ((min_x >= len_x) || (raw > (len_x - min_x))) begin
      duty_nx = sh_len;
    end else begin
      duty_nx = raw[PWM_W-1:0];
    end
  end

  // Next state of step sequencer, dead-time window, PWM counter and gates.
  always_comb begin
    en_rise     = en & ~en_d;
    tick_nx     = en & ~en_rise & (step_cnt == STEP_ZERO);
    step_nx     = m3_step;
    step_cnt_nx = step_cnt;
    dead_nx     = dead;

    if (tick_nx) begin
      step_nx = step_adv(m3_step, dir);
    end else begin
      step_nx = m3_step;
    end

    if (!en || en_rise) begin
      step_cnt_nx = reload_start(m3reg_step_cnt_reload1);
    end else if (step_cnt == STEP_ZERO) begin
      step_cnt_nx = reload_start(sh_reload);
    end else begin
      step_cnt_nx = step_cnt - STEP_ONE;
    end

    if (!en || en_rise || tick_nx) begin
      dead_nx = DEAD_LD;
    end else if (dead != DEAD_ZERO) begin
      dead_nx = dead - DEAD_ONE;
    end else begin
      dead_nx = DEAD_ZERO;
    end

    // PWM starts only once the first dead window after enable has expired;
    // later dead windows just mask the gates while the PWM keeps running.
    run_nx      = en & (pwm_run | (dead_nx == DEAD_ZERO));
    start_first = run_nx & ~pwm_run;
    wrap        = pwm_run & (sh_len >= LEN_TWO) & (pwm_cnt == (sh_len - LEN_ONE));
    // With a period shorter than 2 there is nothing running to protect, so the
    // shadows keep reloading every cycle until a usable length shows up.
    held_off    = pwm_run & (sh_len < LEN_TWO);
    ps_nx       = run_nx & (start_first | wrap | held_off);
    load_sh     = en_rise | ps_nx;

    if (!run_nx || ps_nx) begin
      pwm_cnt_nx = LEN_ZERO;
    end else begin
      pwm_cnt_nx = pwm_cnt + LEN_ONE;
    end

    if (ps_nx) begin
      duty_use_nx = duty;
    end else begin
      duty_use_nx = duty_use;
    end

    if (load_sh) begin
      len_gov = pwmLenWant;
    end else begin
      len_gov = sh_len;
    end
    len_ok_nx  = (len_gov >= LEN_TWO);
    pwm_out_nx = run_nx & len_ok_nx & (pwm_cnt_nx < duty_use_nx);
    pulse_nx   = ps_nx & len_ok_nx;

    gate_on = en & (dead_nx == DEAD_ZERO);
    if (gate_on) begin
      lo_nx = lo_pat(step_nx);
    end else begin
      lo_nx = 3'b000;
    end
    if (gate_on && pwm_out_nx) begin
      hi_nx = hi_pat(step_nx);
    end else begin
      hi_nx = 3'b000;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (nRst) begin
      en_d             <= 1'b0;
      sh_reload        <= STEP_ZERO;
      sh_pct           <= PCT_ZERO;
      sh_len           <= LEN_ZERO;
      sh_min           <= LEN_ZERO;
      duty             <= LEN_ZERO;
      duty_use         <= LEN_ZERO;
      pwm_cnt          <= LEN_ZERO;
      pwm_run          <= 1'b0;
      step_cnt         <= STEP_ZERO;
      dead             <= DEAD_LD;
      m3_step          <= 3'd0;
      m3_step_tick     <= 1'b0;
      pwm_period_start <= 1'b0;
      pwm_out          <= 1'b0;
      m3_hi            <= 3'b000;
      m3_lo            <= 3'b000;
    end else begin
      en_d <= en;
      if (load_sh) begin
        sh_pct <= m3reg_power_percent;
        sh_len <= pwmLenWant;
        sh_min <= pwmMinMask;
      end
      if (load_sh || tick_nx) begin
        sh_reload <= m3reg_step_cnt_reload1;
      end
      duty             <= duty_nx;
      duty_use         <= duty_use_nx;
      pwm_cnt          <= pwm_cnt_nx;
      pwm_run          <= run_nx;
      step_cnt         <= step_cnt_nx;
      dead             <= dead_nx;
      m3_step          <= step_nx;
      m3_step_tick     <= tick_nx;
      pwm_period_start <= pulse_nx;
      pwm_out          <= pwm_out_nx;
      m3_hi            <= hi_nx;
      m3_lo            <= lo_nx;
    end
  end

endmodule

// File: tb/tb_motoro3_step_pwm.sv
// Directed bench for motoro3_step_pwm: reload=40, len=16, min=2, DEAD=16.
// Positions in comments are clock edges counted from the first edge with en=1.
module tb_motoro3_step_pwm;

  logic        clk;
  logic        nRst;
  logic        en;
  logic        dir;
  logic [24:0] reload;
  logic [7:0]  pct;
  logic [11:0] len;
  logic [11:0] mmin;
  logic [2:0]  m3_step;
  logic        m3_step_tick;
  logic        pwm_period_start;
  logic        pwm_out;
  logic [2:0]  m3_hi;
  logic [2:0]  m3_lo;

  int checks   = 0;
  int failures = 0;

  motoro3_step_pwm dut (
    .clk                    (clk),
    .nRst                   (nRst),
    .en                     (en),
    .dir                    (dir),
    .m3reg_step_cnt_reload1 (reload),
    .m3reg_power_percent    (pct),
    .pwmLenWant             (len),
    .pwmMinMask             (mmin),
    .m3_step                (m3_step),
    .m3_step_tick           (m3_step_tick),
    .pwm_period_start       (pwm_period_start),
    .pwm_out                (pwm_out),
    .m3_hi                  (m3_hi),
    .m3_lo                  (m3_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s failed", tag);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Gate safety invariant, checked on every cycle.
  always @(negedge clk) begin
    checks++;
    assert (((m3_hi & m3_lo) == 3'b000) && ($countones(m3_hi) <= 1) && ($countones(m3_lo) <= 1)) else begin
      failures++;
      $display("FAIL invariant observed hi=%b lo=%b expected disjoint single bits", m3_hi, m3_lo);
      $error("invariant failed");
    end
  end

  logic [2:0] exp_step [5] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
  logic [2:0] exp_lo   [5] = '{3'b100, 3'b001, 3'b001, 3'b010, 3'b010};

  initial begin
    nRst = 1'b1; en = 1'b0; dir = 1'b0;
    reload = 25'd40; pct = 8'h40; len = 12'd16; mmin = 12'd2;
    cyc(2);
    chk("rst_step", 32'(m3_step), 32'd0);
    chk("rst_tick", 32'(m3_step_tick), 32'd0);
    chk("rst_ps",   32'(pwm_period_start), 32'd0);
    chk("rst_pwm",  32'(pwm_out), 32'd0);
    chk("rst_hi",   32'(m3_hi), 32'd0);
    chk("rst_lo",   32'(m3_lo), 32'd0);
    nRst = 1'b0;
    cyc(3);
    chk("dis_lo",   32'(m3_lo), 32'd0);
    chk("dis_pwm",  32'(pwm_out), 32'd0);

    // Enable: 16-clock dead window, then PWM starts at count 0 with duty 4.
    en = 1'b1;
    cyc(1);  // p0
    chk("en_dead_hi", 32'(m3_hi), 32'd0);
    chk("en_dead_lo", 32'(m3_lo), 32'd0);
    cyc(15); // p15
    chk("en_dead_end_lo", 32'(m3_lo), 32'd0);
    chk("en_dead_end_ps", 32'(pwm_period_start), 32'd0);
    cyc(1);  // p16
    chk("start_ps",  32'(pwm_period_start), 32'd1);
    chk("start_pwm", 32'(pwm_out), 32'd1);
    chk("start_hi",  32'(m3_hi), 32'b001);
    chk("start_lo",  32'(m3_lo), 32'b010);
    chk("start_step", 32'(m3_step), 32'd0);
    cyc(3);  // p19 cnt3
    chk("duty4_last_on", 32'(pwm_out), 32'd1);
    cyc(1);  // p20 cnt4
    chk("duty4_off", 32'(pwm_out), 32'd0);
    chk("duty4_hi_off", 32'(m3_hi), 32'd0);
    chk("duty4_lo", 32'(m3_lo), 32'b010);
    cyc(12); // p32
    chk("period2_ps", 32'(pwm_period_start), 32'd1);
    cyc(7);  // p39
    chk("pre_tick_step", 32'(m3_step), 32'd0);
    chk("pre_tick", 32'(m3_step_tick), 32'd0);
    cyc(1);  // p40
    chk("tick1", 32'(m3_step_tick), 32'd1);
    chk("tick1_step", 32'(m3_step), 32'd1);
    chk("tick1_hi", 32'(m3_hi), 32'd0);
    chk("tick1_lo", 32'(m3_lo), 32'd0);
    cyc(15); // p55
    chk("dead16_lo", 32'(m3_lo), 32'd0);
    cyc(1);  // p56
    chk("after_dead_lo", 32'(m3_lo), 32'b100);
    chk("after_dead_hi", 32'(m3_hi), 32'd0);
    cyc(8);  // p64
    chk("step1_hi", 32'(m3_hi), 32'b001);
    cyc(16); // p80
    for (int i = 0; i < 5; i++) begin
      chk("seq_step", 32'(m3_step), 32'(exp_step[i]));
      chk("seq_tick", 32'(m3_step_tick), 32'd1);
      cyc(20);
      chk("seq_lo", 32'(m3_lo), 32'(exp_lo[i]));
      cyc(20);
    end
    // p280, step 1. Mid-period pct change: 0x80 -> duty 8, applies from p304.
    pct = 8'h80;
    cyc(12); // p292 cnt4
    chk("old_duty_kept", 32'(pwm_out), 32'd0);
    cyc(16); // p308 cnt4
    chk("new_duty_on", 32'(pwm_out), 32'd1);
    chk("new_duty_hi", 32'(m3_hi), 32'b001);
    cyc(4);  // p312 cnt8
    chk("new_duty_off", 32'(pwm_out), 32'd0);
    // pct 8: raw 0 clamps to min 2, applies from p336.
    pct = 8'h08;
    cyc(25); // p337
    chk("min_clamp_on", 32'(pwm_out), 32'd1);
    cyc(1);  // p338
    chk("min_clamp_off", 32'(pwm_out), 32'd0);
    // pct 0: duty 0 from p368.
    pct = 8'h00;
    cyc(30); // p368
    chk("pct0_pwm", 32'(pwm_out), 32'd0);
    cyc(16); // p384
    chk("pct0_ps", 32'(pwm_period_start), 32'd1);
    chk("pct0_pwm2", 32'(pwm_out), 32'd0);
    chk("pct0_hi", 32'(m3_hi), 32'd0);
    chk("pct0_lo", 32'(m3_lo), 32'b001);
    // pct 0xFF: raw 15 > 14 -> duty = len, from p416.
    pct = 8'hFF;
    cyc(47); // p431 cnt15
    chk("full_pwm", 32'(pwm_out), 32'd1);
    chk("full_hi", 32'(m3_hi), 32'b100);
    chk("full_lo", 32'(m3_lo), 32'b001);
    cyc(1);  // p432
    chk("full_ps", 32'(pwm_period_start), 32'd1);
    chk("full_pwm2", 32'(pwm_out), 32'd1);
    // len 1: PWM held off from the p448 boundary.
    len = 12'd1;
    cyc(16); // p448
    chk("len1_ps", 32'(pwm_period_start), 32'd0);
    chk("len1_pwm", 32'(pwm_out), 32'd0);
    chk("len1_hi", 32'(m3_hi), 32'd0);
    cyc(8);  // p456
    chk("len1_ps2", 32'(pwm_period_start), 32'd0);
    chk("len1_pwm2", 32'(pwm_out), 32'd0);
    cyc(4);  // p460
    chk("len1_lo", 32'(m3_lo), 32'b010);
    len = 12'd16; pct = 8'h40;
    cyc(1);  // p461
    chk("len_back_ps", 32'(pwm_period_start), 32'd1);
    cyc(19); // p480 (period from p477, cnt3)
    chk("len_back_on", 32'(pwm_out), 32'd1);
    cyc(1);  // p481
    chk("len_back_off", 32'(pwm_out), 32'd0);
    // Reverse direction: 0 -> 5 -> 4 -> 3.
    dir = 1'b1;
    cyc(39); // p520
    chk("rev_step5", 32'(m3_step), 32'd5);
    chk("rev_tick", 32'(m3_step_tick), 32'd1);
    chk("rev_lo_dead", 32'(m3_lo), 32'd0);
    cyc(15); // p535
    chk("rev_dead_end", 32'(m3_lo), 32'd0);
    cyc(1);  // p536
    chk("rev_lo", 32'(m3_lo), 32'b010);
    cyc(24); // p560
    chk("rev_step4", 32'(m3_step), 32'd4);
    cyc(40); // p600
    chk("rev_step3", 32'(m3_step), 32'd3);
    // Enable low mid-step.
    cyc(10); // p610
    en = 1'b0;
    cyc(1);  // p611
    chk("enlo_hi", 32'(m3_hi), 32'd0);
    chk("enlo_lo", 32'(m3_lo), 32'd0);
    chk("enlo_pwm", 32'(pwm_out), 32'd0);
    chk("enlo_step", 32'(m3_step), 32'd3);
    cyc(4);  // p615
    chk("enlo_step_held", 32'(m3_step), 32'd3);
    en = 1'b1;
    cyc(16); // p631
    chk("reen_dead_lo", 32'(m3_lo), 32'd0);
    chk("reen_dead_ps", 32'(pwm_period_start), 32'd0);
    cyc(1);  // p632
    chk("reen_ps", 32'(pwm_period_start), 32'd1);
    chk("reen_hi", 32'(m3_hi), 32'b010);
    chk("reen_lo", 32'(m3_lo), 32'b001);
    cyc(23); // p655
    chk("reen_pre_tick", 32'(m3_step_tick), 32'd0);
    cyc(1);  // p656
    chk("reen_tick_step", 32'(m3_step), 32'd2);
    // Reset mid-run, then restart from step 0.
    cyc(4);  // p660
    nRst = 1'b1;
    cyc(1);  // p661
    chk("mrst_step", 32'(m3_step), 32'd0);
    chk("mrst_pwm", 32'(pwm_out), 32'd0);
    chk("mrst_hi", 32'(m3_hi), 32'd0);
    chk("mrst_lo", 32'(m3_lo), 32'd0);
    chk("mrst_ps", 32'(pwm_period_start), 32'd0);
    nRst = 1'b0;
    cyc(16); // p677
    chk("mrst_dead_lo", 32'(m3_lo), 32'd0);
    cyc(1);  // p678
    chk("mrst_start_ps", 32'(pwm_period_start), 32'd1);
    chk("mrst_start_hi", 32'(m3_hi), 32'b001);
    chk("mrst_start_lo", 32'(m3_lo), 32'b010);
    cyc(23); // p701
    chk("mrst_pre_tick", 32'(m3_step), 32'd0);
    cyc(1);  // p702
    chk("mrst_tick_step", 32'(m3_step), 32'd5);
    chk("mrst_tick", 32'(m3_step_tick), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
